// File: rtl/pid_pkg.sv
// Shared widths, FSM state encoding and config field codes for the
// time-multiplexed PID scheduler.
package pid_pkg;

    localparam int POS_W = 13;
    localparam int DEN_W = 8;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        STORE = 3'd3,
        SKIP  = 3'd4
    } state_e;

    localparam logic [2:0] SEL_KP_N = 3'd0;
    localparam logic [2:0] SEL_KP_D = 3'd1;
    localparam logic [2:0] SEL_KI_N = 3'd2;
    localparam logic [2:0] SEL_KI_D = 3'd3;
    localparam logic [2:0] SEL_KD_N = 3'd4;
    localparam logic [2:0] SEL_KD_D = 3'd5;
    localparam logic [2:0] SEL_CLR  = 3'd6;

endpackage

// File: rtl/pid_gain_bank.sv
// Per-channel PID gain registers with host write decode and a read mux
// indexed by the channel currently being serviced.
module pid_gain_bank
    import pid_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [2:0]       cfg_sel,
    input  logic [POS_W-1:0] cfg_data,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [POS_W-1:0] kp_n,
    output logic [DEN_W-1:0] kp_d,
    output logic [POS_W-1:0] ki_n,
    output logic [DEN_W-1:0] ki_d,
    output logic [POS_W-1:0] kd_n,
    output logic [DEN_W-1:0] kd_d
);

    logic [POS_W-1:0] kp_n_q [NCH];
    logic [POS_W-1:0] kp_n_d [NCH];
    logic [DEN_W-1:0] kp_d_q [NCH];
    logic [DEN_W-1:0] kp_d_d [NCH];
    logic [POS_W-1:0] ki_n_q [NCH];
    logic [POS_W-1:0] ki_n_d [NCH];
    logic [DEN_W-1:0] ki_d_q [NCH];
    logic [DEN_W-1:0] ki_d_d [NCH];
    logic [POS_W-1:0] kd_n_q [NCH];
    logic [POS_W-1:0] kd_n_d [NCH];
    logic [DEN_W-1:0] kd_d_q [NCH];
    logic [DEN_W-1:0] kd_d_d [NCH];

    logic            wr_ok_s;
    logic [CH_W-1:0] wr_ch_s;

    // Decode a host write: out-of-range channels and non-gain selects are dropped.
    always_comb begin
        wr_ok_s = cfg_we && ({29'd0, cfg_ch} < 32'(NCH));
        wr_ch_s = cfg_ch[CH_W-1:0];
        kp_n_d  = kp_n_q;
        kp_d_d  = kp_d_q;
        ki_n_d  = ki_n_q;
        ki_d_d  = ki_d_q;
        kd_n_d  = kd_n_q;
        kd_d_d  = kd_d_q;
        if (wr_ok_s) begin
            case (cfg_sel)
                SEL_KP_N: kp_n_d[wr_ch_s] = cfg_data;
                SEL_KP_D: kp_d_d[wr_ch_s] = cfg_data[DEN_W-1:0];
                SEL_KI_N: ki_n_d[wr_ch_s] = cfg_data;
                SEL_KI_D: ki_d_d[wr_ch_s] = cfg_data[DEN_W-1:0];
                SEL_KD_N: kd_n_d[wr_ch_s] = cfg_data;
                SEL_KD_D: kd_d_d[wr_ch_s] = cfg_data[DEN_W-1:0];
                default:  kp_n_d = kp_n_q;
            endcase
        end else begin
            kp_n_d = kp_n_q;
        end
    end

    // Gain register bank; cleared by reset only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                kp_n_q[i] <= '0;
                kp_d_q[i] <= '0;
                ki_n_q[i] <= '0;
                ki_d_q[i] <= '0;
                kd_n_q[i] <= '0;
                kd_d_q[i] <= '0;
            end
        end else begin
            kp_n_q <= kp_n_d;
            kp_d_q <= kp_d_d;
            ki_n_q <= ki_n_d;
            ki_d_q <= ki_d_d;
            kd_n_q <= kd_n_d;
            kd_d_q <= kd_d_d;
        end
    end

    assign kp_n = kp_n_q[rd_ch];
    assign kp_d = kp_d_q[rd_ch];
    assign ki_n = ki_n_q[rd_ch];
    assign ki_d = ki_d_q[rd_ch];
    assign kd_n = kd_n_q[rd_ch];
    assign kd_d = kd_d_q[rd_ch];

endmodule

// File: rtl/pid_sched.sv
// Sweeps one shared PID datapath across NCH motor channels per sample tick,
// holding per-channel history and output registers.
module pid_sched
    import pid_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int PID_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [NCH-1:0]       enable,
    input  logic [POS_W*NCH-1:0] pos_d_flat,
    input  logic [POS_W*NCH-1:0] pos_flat,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_ch,
    input  logic [2:0]           cfg_sel,
    input  logic [POS_W-1:0]     cfg_data,
    output logic [POS_W-1:0]     pid_pos_d,
    output logic [POS_W-1:0]     pid_pos,
    output logic [POS_W-1:0]     pid_err_prev,
    output logic [POS_W-1:0]     pid_int_err_prev,
    output logic [POS_W-1:0]     pid_Kp_n,
    output logic [POS_W-1:0]     pid_Ki_n,
    output logic [POS_W-1:0]     pid_Kd_n,
    output logic [DEN_W-1:0]     pid_Kp_d,
    output logic [DEN_W-1:0]     pid_Ki_d,
    output logic [DEN_W-1:0]     pid_Kd_d,
    input  logic [POS_W-1:0]     pid_pwm,
    input  logic [POS_W-1:0]     pid_err,
    input  logic [POS_W-1:0]     pid_int_err,
    input  logic                 pid_dir,
    output logic [POS_W*NCH-1:0] pwm_flat,
    output logic [NCH-1:0]       dir,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int CH_W = (NCH > 2) ? $clog2(NCH) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, ch_nxt_s, clr_idx_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d, busy_q, busy_d;
    logic              clr_pend_q, clr_pend_d, clr_hit_s, advance_s;
    logic [POS_W-1:0]  pwm_q [NCH];
    logic [POS_W-1:0]  pwm_d [NCH];
    logic [POS_W-1:0]  err_prev_q [NCH];
    logic [POS_W-1:0]  err_prev_d [NCH];
    logic [POS_W-1:0]  int_prev_q [NCH];
    logic [POS_W-1:0]  int_prev_d [NCH];
    logic [NCH-1:0]    dir_q, dir_d;
    logic [POS_W-1:0]  pos_d_q, pos_d_d, pos_q, pos_d2, errp_q, errp_d, intp_q, intp_d;
    logic [POS_W-1:0]  kpn_q, kpn_d, kin_q, kin_d, kdn_q, kdn_d;
    logic [DEN_W-1:0]  kpd_q, kpd_d, kid_q, kid_d, kdd_q, kdd_d;
    logic [POS_W-1:0]  g_kpn_s, g_kin_s, g_kdn_s;
    logic [DEN_W-1:0]  g_kpd_s, g_kid_s, g_kdd_s;

    pid_gain_bank #(.NCH(NCH), .CH_W(CH_W)) u_gains (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .rd_ch    (ch_q),
        .kp_n     (g_kpn_s),
        .kp_d     (g_kpd_s),
        .ki_n     (g_kin_s),
        .ki_d     (g_kid_s),
        .kd_n     (g_kdn_s),
        .kd_d     (g_kdd_s)
    );

    // Sweep FSM: channel walk, datapath operand load, result capture and history clear.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        clr_pend_d = clr_pend_q;
        pwm_d      = pwm_q;
        dir_d      = dir_q;
        err_prev_d = err_prev_q;
        int_prev_d = int_prev_q;
        pos_d_d    = pos_d_q;
        pos_d2     = pos_q;
        errp_d     = errp_q;
        intp_d     = intp_q;
        kpn_d      = kpn_q;
        kin_d      = kin_q;
        kdn_d      = kdn_q;
        kpd_d      = kpd_q;
        kid_d      = kid_q;
        kdd_d      = kdd_q;
        advance_s  = 1'b0;
        ch_nxt_s   = ch_q + CH_W'(1);
        clr_idx_s  = cfg_ch[CH_W-1:0];
        clr_hit_s  = cfg_we && (cfg_sel == SEL_CLR) && ({29'd0, cfg_ch} < 32'(NCH));

        case (state_q)
            IDLE: begin
                if (tick) begin
                    ch_d    = '0;
                    state_d = enable[0] ? LOAD : SKIP;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                pos_d_d    = pos_d_flat[POS_W*int'(ch_q) +: POS_W];
                pos_d2     = pos_flat[POS_W*int'(ch_q) +: POS_W];
                errp_d     = err_prev_q[ch_q];
                intp_d     = int_prev_q[ch_q];
                kpn_d      = g_kpn_s;
                kin_d      = g_kin_s;
                kdn_d      = g_kdn_s;
                kpd_d      = g_kpd_s;
                kid_d      = g_kid_s;
                kdd_d      = g_kdd_s;
                cnt_d      = CNT_W'(PID_LAT);
                clr_pend_d = 1'b0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = STORE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STORE: begin
                pwm_d[ch_q] = pid_pwm;
                dir_d[ch_q] = pid_dir;
                if (clr_pend_q) begin
                    err_prev_d[ch_q] = '0;
                    int_prev_d[ch_q] = '0;
                end else begin
                    err_prev_d[ch_q] = pid_err;
                    int_prev_d[ch_q] = pid_int_err;
                end
                advance_s = 1'b1;
            end
            SKIP: begin
                pwm_d[ch_q]      = '0;
                dir_d[ch_q]      = 1'b0;
                err_prev_d[ch_q] = '0;
                int_prev_d[ch_q] = '0;
                advance_s        = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (advance_s) begin
            if (ch_q == CH_LAST) begin
                done_d  = 1'b1;
                ch_d    = '0;
                state_d = IDLE;
            end else begin
                ch_d    = ch_nxt_s;
                state_d = enable[ch_nxt_s] ? LOAD : SKIP;
            end
        end else begin
            done_d = 1'b0;
        end

        // A clear aimed at the channel in flight also poisons its pending STORE.
        if (clr_hit_s) begin
            err_prev_d[clr_idx_s] = '0;
            int_prev_d[clr_idx_s] = '0;
            if ((clr_idx_s == ch_q) && ((state_q == LOAD) || (state_q == WAIT))) begin
                clr_pend_d = 1'b1;
            end else begin
                clr_pend_d = clr_pend_d;
            end
        end else begin
            clr_pend_d = clr_pend_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State, history and operand registers; reset aborts any sweep in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            clr_pend_q <= 1'b0;
            dir_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                pwm_q[i]      <= '0;
                err_prev_q[i] <= '0;
                int_prev_q[i] <= '0;
            end
            pos_d_q <= '0;
            pos_q   <= '0;
            errp_q  <= '0;
            intp_q  <= '0;
            kpn_q   <= '0;
            kin_q   <= '0;
            kdn_q   <= '0;
            kpd_q   <= '0;
            kid_q   <= '0;
            kdd_q   <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            clr_pend_q <= clr_pend_d;
            dir_q      <= dir_d;
            pwm_q      <= pwm_d;
            err_prev_q <= err_prev_d;
            int_prev_q <= int_prev_d;
            pos_d_q    <= pos_d_d;
            pos_q      <= pos_d2;
            errp_q     <= errp_d;
            intp_q     <= intp_d;
            kpn_q      <= kpn_d;
            kin_q      <= kin_d;
            kdn_q      <= kdn_d;
            kpd_q      <= kpd_d;
            kid_q      <= kid_d;
            kdd_q      <= kdd_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pwm
        assign pwm_flat[POS_W*g +: POS_W] = pwm_q[g];
    end

    assign dir              = dir_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign overrun          = tick && (state_q != IDLE);
    assign pid_pos_d        = pos_d_q;
    assign pid_pos          = pos_q;
    assign pid_err_prev     = errp_q;
    assign pid_int_err_prev = intp_q;
    assign pid_Kp_n         = kpn_q;
    assign pid_Ki_n         = kin_q;
    assign pid_Kd_n         = kdn_q;
    assign pid_Kp_d         = kpd_q;
    assign pid_Ki_d         = kid_q;
    assign pid_Kd_d         = kdd_q;

endmodule

// File: tb/tb_pid_sched.sv
// Scoreboard bench for pid_sched: a stand-in pid with PID_LAT pipeline stages,
// a per-sweep reference model, and a monitor that checks each done pulse.
module tb_pid_sched;

    localparam int NCH = 4;
    localparam int LAT = 3;
    localparam int W   = 13;

    logic             clk = 1'b0;
    logic             rst_n, tick, cfg_we;
    logic [NCH-1:0]   enable;
    logic [W*NCH-1:0] pos_d_flat, pos_flat;
    logic [2:0]       cfg_ch, cfg_sel;
    logic [W-1:0]     cfg_data;
    logic [W-1:0]     pid_pos_d, pid_pos, pid_err_prev, pid_int_err_prev;
    logic [W-1:0]     pid_Kp_n, pid_Ki_n, pid_Kd_n;
    logic [7:0]       pid_Kp_d, pid_Ki_d, pid_Kd_d;
    logic [W-1:0]     pid_pwm, pid_err, pid_int_err;
    logic             pid_dir;
    logic [W*NCH-1:0] pwm_flat;
    logic [NCH-1:0]   dir;
    logic             busy, done, overrun;

    pid_sched #(.NCH(NCH), .PID_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
        .pos_d_flat(pos_d_flat), .pos_flat(pos_flat),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .pid_pos_d(pid_pos_d), .pid_pos(pid_pos), .pid_err_prev(pid_err_prev),
        .pid_int_err_prev(pid_int_err_prev), .pid_Kp_n(pid_Kp_n), .pid_Ki_n(pid_Ki_n),
        .pid_Kd_n(pid_Kd_n), .pid_Kp_d(pid_Kp_d), .pid_Ki_d(pid_Ki_d), .pid_Kd_d(pid_Kd_d),
        .pid_pwm(pid_pwm), .pid_err(pid_err), .pid_int_err(pid_int_err), .pid_dir(pid_dir),
        .pwm_flat(pwm_flat), .dir(dir), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in controller law; returns {dir, pwm, err, int_err}.
    function automatic logic [39:0] pid_f(input logic [W-1:0] pd, p, ep, ip, kpn, kin, kdn,
                                          input logic [7:0] kpd, kid, kdd);
        logic [W-1:0] e, in, pw;
        logic         dr;
        e  = pd - p;
        in = ip + e;
        pw = W'(kpn * e) + W'(kin * in) + W'(kdn * (e - ep))
           + {5'd0, kpd} + {5'd0, kid} + {5'd0, kdd};
        dr = e[W-1] ^ kpd[0];
        return {dr, pw, e, in};
    endfunction

    logic [39:0] pipe_q [LAT];
    always @(posedge clk) begin
        pipe_q[0] <= pid_f(pid_pos_d, pid_pos, pid_err_prev, pid_int_err_prev,
                           pid_Kp_n, pid_Ki_n, pid_Kd_n, pid_Kp_d, pid_Ki_d, pid_Kd_d);
        for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign {pid_dir, pid_pwm, pid_err, pid_int_err} = pipe_q[LAT-1];

    // Reference model state
    logic [W-1:0] m_kpn [NCH], m_kin [NCH], m_kdn [NCH], m_err [NCH], m_int [NCH], m_pwm [NCH];
    logic [7:0]   m_kpd [NCH], m_kid [NCH], m_kdd [NCH];
    logic         m_dir [NCH];

    typedef struct {
        int               cyc;
        logic [W*NCH-1:0] pwm;
        logic [NCH-1:0]   dir;
    } exp_t;
    exp_t exp_q [$];

    int vec_cnt = 0, err_cnt = 0, done_cnt = 0, exp_dones = 0;
    int sw_start = 0, sw_done = 0;
    logic check_zero;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_kpn[i] = '0; m_kin[i] = '0; m_kdn[i] = '0; m_kpd[i] = '0; m_kid[i] = '0;
            m_kdd[i] = '0; m_err[i] = '0; m_int[i] = '0; m_pwm[i] = '0; m_dir[i] = 1'b0;
        end
    endtask

    task automatic m_cfg(input int ch, input int sel, input logic [W-1:0] d);
        if (ch < NCH) begin
            case (sel)
                0: m_kpn[ch] = d;
                1: m_kpd[ch] = d[7:0];
                2: m_kin[ch] = d;
                3: m_kid[ch] = d[7:0];
                4: m_kdn[ch] = d;
                5: m_kdd[ch] = d[7:0];
                6: begin m_err[ch] = '0; m_int[ch] = '0; end
                default: ;
            endcase
        end
    endtask

    task automatic cfg_write(input int ch, input int sel, input logic [W-1:0] d);
        cfg_ch = 3'(ch); cfg_sel = 3'(sel); cfg_data = d; cfg_we = 1'b1;
        m_cfg(ch, sel, d);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Predict a whole sweep from the current inputs, then issue the tick.
    task automatic start_sweep(output int t, output int t_done);
        exp_t        e;
        logic [39:0] r;
        int          c;
        t = cyc;
        c = cyc + 1;
        for (int i = 0; i < NCH; i++) begin
            if (enable[i]) begin
                r = pid_f(pos_d_flat[W*i +: W], pos_flat[W*i +: W], m_err[i], m_int[i],
                          m_kpn[i], m_kin[i], m_kdn[i], m_kpd[i], m_kid[i], m_kdd[i]);
                {m_dir[i], m_pwm[i], m_err[i], m_int[i]} = r;
                c += LAT + 2;
            end else begin
                m_dir[i] = 1'b0; m_pwm[i] = '0; m_err[i] = '0; m_int[i] = '0;
                c += 1;
            end
            e.pwm[W*i +: W] = m_pwm[i];
            e.dir[i]        = m_dir[i];
        end
        e.cyc = c;
        t_done = c;
        exp_q.push_back(e);
        exp_dones++;
        sw_start = t;
        sw_done  = c;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt < exp_dones && n < 300) begin @(posedge clk); #1; n++; end
        vec_cnt++;
        if (done_cnt < exp_dones) begin
            err_cnt++;
            $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, exp_dones);
            done_cnt = exp_dones;
        end
    endtask

    task automatic rand_pos();
        for (int i = 0; i < NCH; i++) begin
            pos_d_flat[W*i +: W] = W'($urandom());
            pos_flat[W*i +: W]   = W'($urandom());
        end
    endtask

    task automatic rand_gains();
        for (int i = 0; i < NCH; i++)
            for (int s = 0; s < 6; s++) cfg_write(i, s, W'($urandom()));
    endtask

    // Monitor: status flags every cycle, scoreboard pop on each done pulse.
    always @(negedge clk) begin
        logic eb;
        exp_t e;
        eb = (cyc > sw_start) && (cyc < sw_done);
        chk("busy", 64'(busy), 64'(eb));
        chk("overrun", 64'(overrun), 64'(tick && eb));
        if (check_zero) begin
            chk("zero_pwm", 64'(pwm_flat), 64'd0);
            chk("zero_dir", 64'(dir), 64'd0);
            chk("zero_done", 64'(done), 64'd0);
            chk("zero_pid", 64'(|{pid_pos_d, pid_pos, pid_err_prev, pid_int_err_prev, pid_Kp_n,
                                  pid_Ki_n, pid_Kd_n, pid_Kp_d, pid_Ki_d, pid_Kd_d}), 64'd0);
        end
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("pwm_flat", 64'(pwm_flat), 64'(e.pwm));
                chk("dir", 64'(dir), 64'(e.dir));
            end
        end
    end

    initial begin
        int t, td;
        rst_n = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        enable = '0; pos_d_flat = '0; pos_flat = '0; check_zero = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1 check_zero = 1'b0;

        // Single enabled channel, proportional only
        cfg_write(0, 0, 13'd1);
        enable = 4'b0001;
        pos_d_flat[W*0 +: W] = 13'd100;
        start_sweep(t, td); wait_done();

        // All channels, distinct setpoints; second sweep exposes history through Ki
        enable = 4'b1111;
        for (int i = 0; i < NCH; i++) begin
            pos_d_flat[W*i +: W] = W'(100 * (i + 1));
            pos_flat[W*i +: W]   = 13'd0;
            cfg_write(i, 0, 13'd1);
        end
        start_sweep(t, td); wait_done();
        for (int i = 0; i < NCH; i++) cfg_write(i, 2, 13'd1);
        start_sweep(t, td); wait_done();

        // Overrun tick mid-sweep must not disturb timing
        rand_pos();
        start_sweep(t, td);
        wait_until(t + 5);
        tick = 1'b1; @(posedge clk); #1 tick = 1'b0;
        wait_done();

        // Gain write and history clear on ch0 while it waits on the datapath
        cfg_write(0, 4, 13'd3);
        start_sweep(t, td);
        wait_until(t + 2);
        cfg_write(0, 0, 13'd5);
        cfg_write(0, 6, 13'd0);
        wait_done();
        start_sweep(t, td); wait_done();

        // Random sweeps, random config traffic, some back-to-back ticks
        rand_gains();
        for (int k = 0; k < 20; k++) begin
            enable = NCH'($urandom());
            rand_pos();
            for (int j = 0; j < 2; j++)
                cfg_write($urandom_range(0, 7), $urandom_range(0, 7), W'($urandom()));
            start_sweep(t, td);
            if (k % 4 == 3) begin
                wait_until(td);
                rand_pos();
                start_sweep(t, td);
            end
            wait_done();
        end

        // Reset mid-sweep aborts; afterwards a normal sweep runs
        enable = 4'b1111;
        start_sweep(t, td);
        wait_until(t + 10);
        rst_n = 1'b0;
        exp_q.delete();
        exp_dones--;
        sw_done = 0;
        check_zero = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1 check_zero = 1'b0;
        rand_gains();
        rand_pos();
        start_sweep(t, td); wait_done();
        start_sweep(t, td); wait_done();

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
